// File: rtl/online_ccm_iter.sv
// rtl/online_ccm_iter.sv - iterative online constant-coefficient multiplier, one signed power-of-two term per clock
// Define ONLINE_CCM_SKIP_EN to spend RUN cycles only on enabled terms.
module online_ccm_iter #(
    parameter int STAGE  = 4,
    parameter int NTERMS = 4,
    parameter int SMAX   = 7,
    localparam int TG    = $clog2(NTERMS),
    localparam int SW    = $clog2(SMAX + 1),
    localparam int TW    = SW + 2,
    localparam int ACC_D = STAGE + SMAX + TG,
    localparam int ACC_W = ACC_D + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*STAGE-1:0]     x,
    input  logic [NTERMS*TW-1:0]   coef,
    output logic                   busy,
    output logic                   done,
    output logic [2*ACC_D-1:0]     y
);
    localparam int KW = (TG < 1) ? 1 : TG;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  xb_q, xb_d;
    logic [NTERMS*TW-1:0]     coef_q, coef_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     done_q, done_d;
    logic [2*ACC_D-1:0]       y_q, y_d;

    logic [STAGE-1:0]         xp, xm;
    logic signed [ACC_W-1:0]  xb_in;
    logic [TW-1:0]            term;
    logic [SW-1:0]            shamt;
    logic signed [ACC_W-1:0]  addend;
    logic                     acc_neg;
    logic [ACC_D-1:0]         abs_acc;
    logic [2*ACC_D-1:0]       y_enc;

`ifdef ONLINE_CCM_SKIP_EN
    logic [NTERMS-1:0]        pend_q, pend_d;
    logic [NTERMS-1:0]        en_in;
    logic [NTERMS-1:0]        pend_left;

    function automatic logic [KW-1:0] first_set(input logic [NTERMS-1:0] m);
        first_set = '0;
        for (int i = NTERMS - 1; i >= 0; i--) begin
            if (m[i]) first_set = KW'(i);
        end
    endfunction
`endif

    // Signed-digit operand to two's complement: plus digits minus minus digits.
    always_comb begin
        xp = '0;
        xm = '0;
        for (int i = 0; i < STAGE; i++) begin
            xp[i] = x[2*i+1];
            xm[i] = x[2*i];
        end
        xb_in = ACC_W'(xp) - ACC_W'(xm);
    end

    assign term = coef_q[k_q*TW +: TW];

    always_comb begin
        shamt = term[SW-1:0];
        if (int'(term[SW-1:0]) > SMAX) shamt = SW'(SMAX);
        addend = xb_q <<< shamt;
    end

    // Sign-magnitude SD encoding: all magnitude bits on one polarity.
    always_comb begin
        acc_neg = acc_q[ACC_W-1];
        abs_acc = acc_neg ? ACC_D'(-acc_q) : ACC_D'(acc_q);
        y_enc   = '0;
        for (int i = 0; i < ACC_D; i++) begin
            y_enc[2*i+1] = ~acc_neg & abs_acc[i];
            y_enc[2*i]   =  acc_neg & abs_acc[i];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xb_d    = xb_q;
        coef_d  = coef_q;
        k_d     = k_q;
        done_d  = 1'b0;
        y_d     = y_q;
`ifdef ONLINE_CCM_SKIP_EN
        pend_d    = pend_q;
        pend_left = pend_q & ~(NTERMS'(1) << k_q);
        en_in     = '0;
        for (int i = 0; i < NTERMS; i++) en_in[i] = coef[i*TW+TW-1];
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xb_d   = xb_in;
                    coef_d = coef;
                    acc_d  = '0;
                    k_d    = '0;
`ifdef ONLINE_CCM_SKIP_EN
                    pend_d  = en_in;
                    k_d     = first_set(en_in);
                    state_d = (en_in == '0) ? S_DONE : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (term[TW-1]) begin
                    acc_d = term[TW-2] ? (acc_q - addend) : (acc_q + addend);
                end
`ifdef ONLINE_CCM_SKIP_EN
                pend_d = pend_left;
                k_d    = first_set(pend_left);
                if (pend_left == '0) state_d = S_DONE;
`else
                if (k_q == KW'(NTERMS - 1)) state_d = S_DONE;
                else                        k_d = k_q + KW'(1);
`endif
            end
            S_DONE: begin
                y_d     = y_enc;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            xb_q    <= '0;
            coef_q  <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            y_q     <= '0;
`ifdef ONLINE_CCM_SKIP_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xb_q    <= xb_d;
            coef_q  <= coef_d;
            k_q     <= k_d;
            done_q  <= done_d;
            y_q     <= y_d;
`ifdef ONLINE_CCM_SKIP_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign y    = y_q;

endmodule
